// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM states, frame width and default bit timing.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam int UART_DATA_BITS       = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 868;

endpackage

// File: rtl/uart_rx_frame_if.sv
// Receive-side bundle: serial line into the framer, parallel frame out to the parity checker.
interface uart_rx_frame_if;
  import uart_pkg::*;

  logic                      rx;
  logic [UART_DATA_BITS-1:0] data;
  logic                      pbit;
  logic                      pload;
  logic                      stoperror;
  logic                      busy;

  modport master (input rx, output data, output pbit, output pload, output stoperror, output busy);
  modport slave  (output rx, input data, input pbit, input pload, input stoperror, input busy);
endinterface

// File: rtl/uart_rx_frame_sync_2ff.sv
// Two-flop synchroniser for an asynchronous single-bit input, with a selectable reset value.
module sync_2ff #(
  parameter bit RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_frame.sv
// UART receive framer: 8 data bits LSB-first, one parity bit, one stop bit, sampled at mid-bit.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic           clk,
  input  logic           rst,
  uart_rx_frame_if.master bus
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    LAST_BIT  = 3'(UART_DATA_BITS - 1);

  state_t                    state;
  logic [CW-1:0]             cnt;
  logic [2:0]                bit_cnt;
  logic [UART_DATA_BITS-1:0] shift;
  logic                      par;
  logic                      rx_s;
  logic                      tick;

  logic [UART_DATA_BITS-1:0] data_q;
  logic                      pbit_q;
  logic                      pload_q;
  logic                      stoperror_q;
  logic                      busy_q;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.rx),
    .q   (rx_s)
  );

  assign tick = (cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_cnt     <= '0;
      shift       <= '0;
      par         <= 1'b0;
      data_q      <= '0;
      pbit_q      <= 1'b0;
      pload_q     <= 1'b0;
      stoperror_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      pload_q <= 1'b0;
      // Outside IDLE the counter free-runs down and reloads a full bit on every sample point.
      if (state != IDLE) cnt <= tick ? FULL_LOAD : cnt - CW'(1);
      case (state)
        IDLE: begin
          if (!rx_s) begin
            bit_cnt <= '0;
            cnt     <= HALF_LOAD;
            state   <= START;
          end
        end
        START: begin
          if (tick) begin
            if (!rx_s) begin
              state  <= DATA;
              busy_q <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        DATA: begin
          if (tick) begin
            shift   <= {rx_s, shift[UART_DATA_BITS-1:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == LAST_BIT) state <= PARITY;
          end
        end
        PARITY: begin
          if (tick) begin
            par   <= rx_s;
            state <= STOP;
          end
        end
        STOP: begin
          // Leaving at mid-stop-bit leaves half a bit to catch a back-to-back start edge.
          if (tick) begin
            pload_q     <= 1'b1;
            data_q      <= shift;
            pbit_q      <= par;
            stoperror_q <= ~rx_s;
            busy_q      <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.data      = data_q;
  assign bus.pbit      = pbit_q;
  assign bus.pload     = pload_q;
  assign bus.stoperror = stoperror_q;
  assign bus.busy      = busy_q;

endmodule
